// File: rtl/dmactl_pkg.sv
// Shared constants for the dmactl DMA controller: register map, CTRL/STATUS
// bit positions and FSM state encoding.
package dmactl_pkg;

  // Slave register offsets (AD[2:0])
  localparam logic [2:0] REG_SRC_H  = 3'd0;
  localparam logic [2:0] REG_SRC_L  = 3'd1;
  localparam logic [2:0] REG_DST_H  = 3'd2;
  localparam logic [2:0] REG_DST_L  = 3'd3;
  localparam logic [2:0] REG_CNT_H  = 3'd4;
  localparam logic [2:0] REG_CNT_L  = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_SRC_FIX = 1;
  localparam int CTRL_DST_FIX = 2;
  localparam int CTRL_ABORT   = 6;
  localparam int CTRL_IEN     = 7;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_ABORTED = 1;
  localparam int STAT_DONE    = 7;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_YIELD = 3'd4;

endpackage

// File: rtl/dmactl.sv
// Memory-to-memory DMA controller and bus arbiter for the 6801 system bus.
// CPU programs SRC/DST/CNT through the slave port, then the controller stalls
// the CPU via hold, masters the bus and copies CNT bytes, yielding the bus
// every BURST bytes for YIELD_CYC cycles.
module dmactl
  import dmactl_pkg::*;
#(
  parameter int unsigned HOLD_LAT  = 1,
  parameter int unsigned BURST     = 16,
  parameter int unsigned YIELD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        rw,
  input  logic        cs,
  output logic        irq,
  output logic        hold,
  output logic        grant,
  output logic [15:0] m_ad,
  output logic        m_rw,
  output logic        m_vma,
  output logic [7:0]  m_do,
  input  logic [7:0]  m_di
);

  localparam int unsigned   BW         = $clog2(BURST + 1);
  localparam logic [7:0]    HOLD_LAST  = 8'(HOLD_LAT - 1);
  localparam logic [7:0]    YIELD_LAST = 8'(YIELD_CYC - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic          src_fix_q, src_fix_d, dst_fix_q, dst_fix_d, ien_q, ien_d;
  logic          done_q, done_d, aborted_q, aborted_d, abort_q, abort_d;
  logic [7:0]    buf_q, buf_d, cyc_q, cyc_d;
  logic [BW-1:0] burst_q, burst_d;

  logic busy, reg_wr, status_rd, start_wr, abort_wr, abort_pend;

  assign busy       = (state_q != ST_IDLE);
  assign reg_wr     = cs && !rw;
  assign status_rd  = cs && rw && (AD == REG_STATUS);
  assign start_wr   = reg_wr && (AD == REG_CTRL) && DI[CTRL_START];
  assign abort_wr   = reg_wr && (AD == REG_CTRL) && DI[CTRL_ABORT];
  // An abort written on the very edge a byte finishes is honoured at that edge.
  assign abort_pend = abort_q || abort_wr;

  // Next-state logic: register writes, status clear, transfer FSM
  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    src_fix_d = src_fix_q;
    dst_fix_d = dst_fix_q;
    ien_d     = ien_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    abort_d   = abort_q;
    buf_d     = buf_q;
    cyc_d     = cyc_q;
    burst_d   = burst_q;

    // Configuration is frozen while a transfer runs.
    if (reg_wr && !busy) begin
      case (AD)
        REG_SRC_H: src_d[15:8] = DI;
        REG_SRC_L: src_d[7:0]  = DI;
        REG_DST_H: dst_d[15:8] = DI;
        REG_DST_L: dst_d[7:0]  = DI;
        REG_CNT_H: cnt_d[15:8] = DI;
        REG_CNT_L: cnt_d[7:0]  = DI;
        REG_CTRL: begin
          src_fix_d = DI[CTRL_SRC_FIX];
          dst_fix_d = DI[CTRL_DST_FIX];
          ien_d     = DI[CTRL_IEN];
        end
        default: ;
      endcase
    end

    if (status_rd) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end

    if (abort_wr && busy) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Abort in the same write as start cancels the start outright.
        if (start_wr && !abort_wr) begin
          if (cnt_q != 16'd0) begin
            state_d = ST_REQ;
            done_d  = 1'b0;
            cyc_d   = 8'd0;
            burst_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (cyc_q == HOLD_LAST) begin
          if (abort_pend) begin
            state_d   = ST_IDLE;
            abort_d   = 1'b0;
            aborted_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_RD: begin
        buf_d   = m_di;
        state_d = ST_WR;
      end
      ST_WR: begin
        cnt_d   = cnt_q - 16'd1;
        burst_d = burst_q + 1'b1;
        if (!src_fix_q) src_d = src_q + 16'd1;
        if (!dst_fix_q) dst_d = dst_q + 16'd1;
        if (cnt_q == 16'd1) begin
          // Last byte: a pending abort is moot, the transfer completed.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          abort_d = 1'b0;
        end else if (burst_q == BURST_LAST) begin
          state_d = ST_YIELD;
          cyc_d   = 8'd0;
        end else if (abort_pend) begin
          state_d   = ST_IDLE;
          abort_d   = 1'b0;
          aborted_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_YIELD: begin
        if (cyc_q == YIELD_LAST) begin
          state_d = ST_REQ;
          cyc_d   = 8'd0;
          burst_d = '0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update; asynchronous reset returns everything to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      src_fix_q <= 1'b0;
      dst_fix_q <= 1'b0;
      ien_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
      // NOTE: the byte buffer is reset as well so m_do is never X out of reset.
      buf_q     <= '0;
      cyc_q     <= '0;
      burst_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the comb block uses blocking.
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      src_fix_q <= src_fix_d;
      dst_fix_q <= dst_fix_d;
      ien_q     <= ien_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
      buf_q     <= buf_d;
      cyc_q     <= cyc_d;
      burst_q   <= burst_d;
    end
  end

  // Bus master outputs decoded straight from state so reset drops them at once
  always_comb begin
    hold  = (state_q == ST_REQ) || (state_q == ST_RD) || (state_q == ST_WR);
    grant = (state_q == ST_RD) || (state_q == ST_WR);
    m_vma = grant;
    m_rw  = (state_q != ST_WR);
    m_ad  = 16'h0000;
    m_do  = 8'h00;
    if (state_q == ST_RD) m_ad = src_q;
    if (state_q == ST_WR) begin
      m_ad = dst_q;
      m_do = buf_q;
    end
  end

  assign irq = done_q && ien_q;

  // Slave read mux; start and abort are pulses and read back as 0
  always_comb begin
    DO = 8'h00;
    case (AD)
      REG_SRC_H: DO = src_q[15:8];
      REG_SRC_L: DO = src_q[7:0];
      REG_DST_H: DO = dst_q[15:8];
      REG_DST_L: DO = dst_q[7:0];
      REG_CNT_H: DO = cnt_q[15:8];
      REG_CNT_L: DO = cnt_q[7:0];
      REG_CTRL: begin
        DO[CTRL_SRC_FIX] = src_fix_q;
        DO[CTRL_DST_FIX] = dst_fix_q;
        DO[CTRL_IEN]     = ien_q;
      end
      REG_STATUS: begin
        DO[STAT_BUSY]    = busy;
        DO[STAT_ABORTED] = aborted_q;
        DO[STAT_DONE]    = done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmactl.sv
// Self-checking bench for dmactl: register vector table plus directed
// multi-cycle sequences (copy, zero count, bursts, wrap, abort, reset).
module tb_dmactl;
  import dmactl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  AD;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        rw;
  logic        cs;
  logic        irq;
  logic        hold;
  logic        grant;
  logic [15:0] m_ad;
  logic        m_rw;
  logic        m_vma;
  logic [7:0]  m_do;
  logic [7:0]  m_di;

  dmactl #(.HOLD_LAT(1), .BURST(16), .YIELD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .hold(hold), .grant(grant), .m_ad(m_ad), .m_rw(m_rw),
    .m_vma(m_vma), .m_do(m_do), .m_di(m_di)
  );

  always #5 clk = ~clk;

  // Source memory content is a fixed function of the address.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a[7:0] ^ 8'hA5) + a[15:8];
  endfunction

  assign m_di = pat(m_ad);

  // Bus slave model: records every master read/write, captures write data.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];
  int          hold_cnt = 0;

  always @(posedge clk) begin
    if (m_vma && !m_rw) begin
      mem[m_ad] <= m_do;
      wr_log.push_back(m_ad);
    end
    if (m_vma && m_rw) rd_log.push_back(m_ad);
  end

  always @(negedge clk) if (hold) hold_cnt <= hold_cnt + 1;

  typedef struct {
    logic       wr;
    logic [2:0] ad;
    logic [7:0] data;   // write data, or expected read value
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rd;
  int          n, h0, rb, wb, gaps, errs, run;
  logic [7:0]  gap_val [2];
  logic        trace[$];
  int          runs[$];
  logic [15:0] wrap_rd [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // All CPU tasks start and end on a falling edge.
  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic set_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    cpu_write(REG_SRC_H, s[15:8]);
    cpu_write(REG_SRC_L, s[7:0]);
    cpu_write(REG_DST_H, d[15:8]);
    cpu_write(REG_DST_L, d[7:0]);
    cpu_write(REG_CNT_H, c[15:8]);
    cpu_write(REG_CNT_L, c[7:0]);
  endtask

  task automatic wait_hold_low(input int max_cyc, output int cyc);
    cyc = 0;
    while (hold && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_release", 32'(hold), 32'd0);
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    cpu_read(a, v);
    check(name, 32'(v), 32'(exp));
  endtask

  function automatic logic [31:0] log_at(input int which, input int idx);
    if (which == 0) return (idx < rd_log.size()) ? 32'(rd_log[idx]) : 32'hFFFF_FFFF;
    return (idx < wr_log.size()) ? 32'(wr_log[idx]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, REG_SRC_H,  8'h12};
    vecs[1]  = '{1'b1, REG_SRC_L,  8'h34};
    vecs[2]  = '{1'b1, REG_DST_H,  8'h56};
    vecs[3]  = '{1'b1, REG_DST_L,  8'h78};
    vecs[4]  = '{1'b1, REG_CNT_H,  8'h9A};
    vecs[5]  = '{1'b1, REG_CNT_L,  8'hBC};
    vecs[6]  = '{1'b0, REG_SRC_H,  8'h12};
    vecs[7]  = '{1'b0, REG_SRC_L,  8'h34};
    vecs[8]  = '{1'b0, REG_DST_H,  8'h56};
    vecs[9]  = '{1'b0, REG_DST_L,  8'h78};
    vecs[10] = '{1'b0, REG_CNT_H,  8'h9A};
    vecs[11] = '{1'b0, REG_CNT_L,  8'hBC};
    vecs[12] = '{1'b1, REG_CTRL,   8'hC6};  // abort while idle is ignored
    vecs[13] = '{1'b0, REG_CTRL,   8'h86};
    vecs[14] = '{1'b0, REG_STATUS, 8'h00};
    vecs[15] = '{1'b1, REG_CNT_H,  8'h00};
    vecs[16] = '{1'b1, REG_CNT_L,  8'h00};
    vecs[17] = '{1'b1, REG_CTRL,   8'h01};  // start with CNT=0
    vecs[18] = '{1'b0, REG_STATUS, 8'h80};
    vecs[19] = '{1'b0, REG_STATUS, 8'h00};
    vecs[20] = '{1'b0, REG_CTRL,   8'h00};
    wrap_rd[0] = 16'hFFFE;
    wrap_rd[1] = 16'hFFFF;
    wrap_rd[2] = 16'h0000;

    cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_hold_grant_vma", 32'({hold, grant, m_vma}), 32'd0);
    check("rst_m_rw", 32'(m_rw), 32'd1);
    check("rst_m_ad_do", 32'({m_ad, m_do}), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) read_check($sformatf("rst_reg%0d", i), 3'(i), 8'h00);

    // Register table, including the zero-count start
    h0 = hold_cnt;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].ad, vecs[i].data);
      else read_check($sformatf("vec%0d_reg%0d", i, vecs[i].ad), vecs[i].ad, vecs[i].data);
    end
    check("cnt0_no_hold", 32'(hold_cnt - h0), 32'd0);
    check("vec_irq", 32'(irq), 32'd0);

    // Four-byte copy with interrupt
    set_regs(16'h0100, 16'h2000, 16'd4);
    wb = wr_log.size();
    cpu_write(REG_CTRL, 8'h81);
    check("t1_req", 32'({hold, grant}), 32'b10);
    @(negedge clk);
    check("t1_rd", 32'({grant, m_vma, m_rw, m_ad}), 32'({3'b111, 16'h0100}));
    @(negedge clk);
    check("t1_wr", 32'({grant, m_vma, m_rw, m_ad, m_do}), 32'({3'b110, 16'h2000, pat(16'h0100)}));
    wait_hold_low(40, n);
    check("t1_stall_len", 32'(n), 32'd7);
    check("t1_irq_rise", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_copy%0d", i), 32'(mem[16'h2000 + 16'(i)]), 32'(pat(16'h0100 + 16'(i))));
    check("t1_nwr", 32'(wr_log.size() - wb), 32'd4);
    read_check("t1_cnt_h", REG_CNT_H, 8'h00);
    read_check("t1_cnt_l", REG_CNT_L, 8'h00);
    read_check("t1_src_l", REG_SRC_L, 8'h04);
    read_check("t1_dst_l", REG_DST_L, 8'h04);
    read_check("t1_status", REG_STATUS, 8'h80);
    check("t1_irq_fall", 32'(irq), 32'd0);

    // Forty bytes in three tenures with CPU reads in the gaps
    set_regs(16'h1000, 16'h3000, 16'd40);
    cpu_write(REG_CTRL, 8'h01);
    gaps = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(negedge clk);
        cs = 1'b0;
      end
      trace.push_back(hold);
      if (c > 0 && !hold && trace[c-1] && gaps < 2) begin
        cs = 1'b1; rw = 1'b1; AD = REG_CNT_L;
        #1 gap_val[gaps] = DO;
        gaps++;
      end
    end
    cs = 1'b0;
    check("b_gaps", 32'(gaps), 32'd2);
    check("b_gap0_cnt", 32'(gap_val[0]), 32'h18);
    check("b_gap1_cnt", 32'(gap_val[1]), 32'h08);
    run = 1;
    for (int i = 1; i < trace.size(); i++) begin
      if (trace[i] == trace[i-1]) run++;
      else begin
        runs.push_back(run);
        run = 1;
      end
    end
    runs.push_back(run);
    check("b_first_hold", 32'(trace[0]), 32'd1);
    check("b_nruns", 32'(runs.size()), 32'd6);
    check("b_run_t1", 32'(runs.size() > 0 ? runs[0] : -1), 32'd33);
    check("b_run_y1", 32'(runs.size() > 1 ? runs[1] : -1), 32'd2);
    check("b_run_t2", 32'(runs.size() > 2 ? runs[2] : -1), 32'd33);
    check("b_run_y2", 32'(runs.size() > 3 ? runs[3] : -1), 32'd2);
    check("b_run_t3", 32'(runs.size() > 4 ? runs[4] : -1), 32'd17);
    errs = 0;
    for (int i = 0; i < 40; i++)
      if (mem[16'h3000 + 16'(i)] !== pat(16'h1000 + 16'(i))) errs++;
    check("b_copy_errs", 32'(errs), 32'd0);
    read_check("b_status", REG_STATUS, 8'h80);

    // Source wraps past $FFFF, fixed destination
    set_regs(16'hFFFE, 16'hE6A8, 16'd3);
    rb = rd_log.size();
    wb = wr_log.size();
    cpu_write(REG_CTRL, 8'h05);
    wait_hold_low(40, n);
    check("w_nrd", 32'(rd_log.size() - rb), 32'd3);
    check("w_nwr", 32'(wr_log.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w_rd%0d", i), log_at(0, rb + i), 32'(wrap_rd[i]));
      check($sformatf("w_wr%0d", i), log_at(1, wb + i), 32'h0000_E6A8);
    end
    check("w_data", 32'(mem[16'hE6A8]), 32'(pat(16'h0000)));
    read_check("w_src_h", REG_SRC_H, 8'h00);
    read_check("w_src_l", REG_SRC_L, 8'h01);
    read_check("w_dst_h", REG_DST_H, 8'hE6);
    read_check("w_dst_l", REG_DST_L, 8'hA8);
    read_check("w_status", REG_STATUS, 8'h80);

    // Abort during the fourth byte of a ten-byte transfer
    set_regs(16'h0300, 16'h0400, 16'd10);
    wb = wr_log.size();
    cpu_write(REG_CTRL, 8'h01);
    repeat (7) @(negedge clk);
    check("a_in_rd4", 32'({m_vma, m_rw, m_ad}), 32'({2'b11, 16'h0303}));
    cpu_write(REG_CTRL, 8'h40);
    wait_hold_low(40, n);
    check("a_stop_len", 32'(n), 32'd1);
    check("a_nwr", 32'(wr_log.size() - wb), 32'd4);
    read_check("a_cnt_h", REG_CNT_H, 8'h00);
    read_check("a_cnt_l", REG_CNT_L, 8'h06);
    read_check("a_src_l", REG_SRC_L, 8'h04);
    read_check("a_dst_l", REG_DST_L, 8'h04);
    read_check("a_status", REG_STATUS, 8'h82);
    read_check("a_status_clr", REG_STATUS, 8'h00);

    // Start and abort in one write: nothing happens
    cpu_write(REG_CNT_L, 8'h05);
    h0 = hold_cnt;
    cpu_write(REG_CTRL, 8'h41);
    repeat (5) @(negedge clk);
    check("sa_no_hold", 32'(hold_cnt - h0), 32'd0);
    read_check("sa_status", REG_STATUS, 8'h00);
    read_check("sa_cnt_l", REG_CNT_L, 8'h05);

    // Asynchronous reset in the middle of a write cycle
    set_regs(16'h0100, 16'h2000, 16'd4);
    cpu_write(REG_CTRL, 8'h01);
    n = 0;
    while (!(m_vma && !m_rw) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("r_found_wr", 32'({m_vma, m_rw}), 32'b10);
    #2 rst_n = 1'b0;
    #1 check("r_async_drop", 32'({hold, grant, m_vma}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) read_check($sformatf("r_reg%0d", i), 3'(i), 8'h00);
    check("r_idle", 32'({hold, grant}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
